axi_rd_arbiter: RTL and testbench
=================================

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 SHALL have one clock and one reset: the reset is asynchronous and active-low.
REQ-002 SHALL have parameter MAX_OUTST, default 2, giving the maximum outstanding reads per requester (range 1..3).
REQ-003 SHALL have parameter STARVE_LIM, default 4, giving the consecutive data grants allowed while inst waits.
REQ-004 SHALL provide these ports (name, direction, width, meaning):
- clk  in  1  clock
- resetn  in  1  async active-low reset
- inst_req  in  1  inst read request
- inst_addr  in  32  inst address
- inst_size  in  2  inst size, log2 bytes
- inst_addr_ok  out  1  inst request accepted
- inst_data_ok  out  1  inst read data valid
- inst_rdata  out  32  inst read data
- data_req  in  1  data read request
- data_addr  in  32  data address
- data_size  in  2  data size
- data_addr_ok  out  1  data request accepted
- data_data_ok  out  1  data read data valid
- data_rdata  out  32  data read data
- arid  out  4  AXI AR id
- araddr  out  32  AXI AR address
- arsize  out  3  AXI AR size
- arvalid  out  1  AXI AR valid
- arready  in  1  AXI AR ready
- rid  in  4  AXI R id
- rdata  in  32  AXI R data
- rvalid  in  1  AXI R valid
- rready  out  1  AXI R ready

Function
REQ-005 SHALL implement the AR state machine with states IDLE and SEND.
REQ-006 In IDLE, a requester SHALL be eligible when its req=1 and its outstanding count is below MAX_OUTST.
REQ-007 Data SHALL win over inst when both are eligible, except when the starve counter equals STARVE_LIM; in that case inst SHALL win.
REQ-008 In IDLE with a winner, the block SHALL:
- pulse that requester's addr_ok for one cycle (combinational, same cycle);
- latch addr, {1'b0,size} and id (inst=4'd0, data=4'd1);
- go to SEND.
REQ-009 In SEND, arvalid SHALL be 1 and araddr/arsize/arid SHALL be stable until arready=1; on handshake the block SHALL return to IDLE the next cycle. Maximum acceptance rate is one AR every 2 cycles.
REQ-010 addr_ok SHALL be 0 in SEND and in IDLE for a non-winning requester.
REQ-011 The starve counter SHALL:
- increment on a data grant while inst_req=1;
- clear on an inst grant, or when inst_req=0 at a data grant;
- saturate at STARVE_LIM.
REQ-012 Each requester SHALL have a 2-bit outstanding counter:
- +1 on an AR handshake with its id;
- -1 on an R handshake with its id;
- unchanged when both occur in the same cycle;
- a decrement at 0 SHALL be ignored.
REQ-013 rready SHALL be constant 1 out of reset.
REQ-014 On an R handshake, rdata SHALL be registered into the matching requester's rdata and its data_ok SHALL assert for exactly one cycle, the cycle after the handshake (latency 1).
REQ-015 inst_rdata/data_rdata SHALL hold their last value when data_ok=0.
REQ-016 An R beat with rid not 0 or 1 SHALL be accepted and discarded: no data_ok, no counter change.
REQ-017 Requests not yet granted SHALL NOT be stored; the requester SHALL hold req and addr until addr_ok.

Reset
REQ-018 While resetn=0, the block SHALL hold these values:
- state=IDLE, arvalid=0, araddr=0, arsize=0, arid=0;
- both addr_ok=0, both data_ok=0, both rdata=0;
- rready=0, counters=0, starve=0.
REQ-019 Reset asserted mid-SEND SHALL drop arvalid immediately (asynchronously) and discard the pending request and all outstanding counts.
REQ-020 The first grant SHALL be possible in the first cycle after resetn rises.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- inst_req only, addr 0x1C000000, size 2, arready=1 -> inst_addr_ok pulses in cycle 0; arvalid, arid=0, araddr=0x1C000000, arsize=3'd2 in cycle 1; rvalid rid=0 rdata=0xDEADBEEF -> inst_data_ok=1 and inst_rdata=0xDEADBEEF one cycle later.
- inst_req and data_req held, rvalid=0 -> grants data, data, inst, inst, then none; both counts stay 2 until R beats return.
- inst_req and data_req held, R returns immediately -> after 4 data grants, the 5th grant goes to inst; starve counter clears.
- arready=0 for 5 cycles in SEND -> arvalid and araddr stable for all 5 cycles; no addr_ok pulses.
- AR handshake with id 1 and R beat with rid=1 in the same cycle -> data count unchanged; rid=4'd7 beat -> no data_ok.
- resetn=0 mid-SEND -> arvalid=0 the same cycle; after release, counts=0 and a new grant occurs in the first cycle.

Source files
------------

// File: rtl/axi_rd_arbiter_if.sv
// AXI read-address and read-data channel bundle between the arbiter and the memory port.
interface axi_rd_arbiter_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arsize, arvalid, rready,
    input  arready, rid, rdata, rvalid
  );

  modport slave (
    input  arid, araddr, arsize, arvalid, rready,
    output arready, rid, rdata, rvalid
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Two-requester (inst/data) AXI read arbiter: data has priority with an inst anti-starvation limit,
// per-requester outstanding-read limits, and id-routed single-beat read returns.
module axi_rd_arbiter #(
  parameter int MAX_OUTST  = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  inst_req,
  input  logic [31:0]           inst_addr,
  input  logic [1:0]            inst_size,
  output logic                  inst_addr_ok,
  output logic                  inst_data_ok,
  output logic [31:0]           inst_rdata,
  input  logic                  data_req,
  input  logic [31:0]           data_addr,
  input  logic [1:0]            data_size,
  output logic                  data_addr_ok,
  output logic                  data_data_ok,
  output logic [31:0]           data_rdata,
  axi_rd_arbiter_if.master      axi
);

  localparam int              SW         = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIM);
  localparam logic [1:0]      OUTST_MAX  = 2'(MAX_OUTST);
  localparam logic [3:0]      ID_INST    = 4'd0;
  localparam logic [3:0]      ID_DATA    = 4'd1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t         state_q, state_d;
  logic [31:0]    araddr_q;
  logic [2:0]     arsize_q;
  logic [3:0]     arid_q;
  logic           rready_q;
  logic [1:0]     inst_cnt_q, data_cnt_q;
  logic [SW-1:0]  starve_q;
  logic           grant_inst, grant_data;
  logic           inst_elig, data_elig;
  logic           ar_hs, r_hs;

  function automatic logic [SW-1:0] starve_inc(input logic [SW-1:0] v);
    return (v == STARVE_MAX) ? v : v + SW'(1);
  endfunction

  // Simultaneous issue and return cancel; a return with nothing outstanding is dropped.
  function automatic logic [1:0] outst_next(input logic [1:0] cnt, input logic inc, input logic dec);
    if (inc && !dec)
      return cnt + 2'd1;
    if (dec && !inc && cnt != 2'd0)
      return cnt - 2'd1;
    return cnt;
  endfunction

  assign inst_elig = inst_req && (inst_cnt_q < OUTST_MAX);
  assign data_elig = data_req && (data_cnt_q < OUTST_MAX);
  assign ar_hs     = (state_q == SEND) && axi.arready;
  assign r_hs      = axi.rvalid && rready_q;

  always_comb begin
    state_d    = state_q;
    grant_inst = 1'b0;
    grant_data = 1'b0;
    case (state_q)
      IDLE: begin
        // Gated by resetn so no accept can leak out combinationally while held in reset.
        if (resetn) begin
          grant_inst = inst_elig && (!data_elig || starve_q == STARVE_MAX);
          grant_data = data_elig && !grant_inst;
        end
        if (grant_inst || grant_data)
          state_d = SEND;
      end
      SEND: begin
        if (axi.arready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;
  assign axi.arvalid  = (state_q == SEND);
  assign axi.araddr   = araddr_q;
  assign axi.arsize   = arsize_q;
  assign axi.arid     = arid_q;
  assign axi.rready   = rready_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      araddr_q     <= '0;
      arsize_q     <= '0;
      arid_q       <= '0;
      rready_q     <= 1'b0;
      inst_cnt_q   <= '0;
      data_cnt_q   <= '0;
      starve_q     <= '0;
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      inst_rdata   <= '0;
      data_rdata   <= '0;
    end else begin
      state_q  <= state_d;
      rready_q <= 1'b1;

      // AR stage: request captured at grant, held stable while SEND waits for arready
      if (grant_inst) begin
        araddr_q <= inst_addr;
        arsize_q <= {1'b0, inst_size};
        arid_q   <= ID_INST;
      end else if (grant_data) begin
        araddr_q <= data_addr;
        arsize_q <= {1'b0, data_size};
        arid_q   <= ID_DATA;
      end

      if (grant_inst)
        starve_q <= '0;
      else if (grant_data)
        starve_q <= inst_req ? starve_inc(starve_q) : '0;

      inst_cnt_q <= outst_next(inst_cnt_q, ar_hs && (arid_q == ID_INST), r_hs && (axi.rid == ID_INST));
      data_cnt_q <= outst_next(data_cnt_q, ar_hs && (arid_q == ID_DATA), r_hs && (axi.rid == ID_DATA));

      // R stage: one-cycle data_ok the cycle after the beat; unknown ids are swallowed
      inst_data_ok <= r_hs && (axi.rid == ID_INST);
      data_data_ok <= r_hs && (axi.rid == ID_DATA);
      if (r_hs && axi.rid == ID_INST)
        inst_rdata <= axi.rdata;
      if (r_hs && axi.rid == ID_DATA)
        data_rdata <= axi.rdata;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: single-transaction vector table plus directed arbitration sequences.
module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, data_req;
  logic [31:0] inst_addr, data_addr;
  logic [1:0]  inst_size, data_size;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;

  axi_rd_arbiter_if bus ();

  axi_rd_arbiter #(.MAX_OUTST(2), .STARVE_LIM(4)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_size    (inst_size),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_addr    (data_addr),
    .data_size    (data_size),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .axi          (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_data;
    logic [31:0] val;
  } rexp_t;

  typedef struct {
    bit          ireq;
    bit          dreq;
    logic [31:0] iaddr;
    logic [1:0]  isize;
    logic [31:0] daddr;
    logic [1:0]  dsize;
    logic [31:0] rd;
    logic [1:0]  exp_ok;
    logic [3:0]  exp_id;
    logic [31:0] exp_addr;
    logic [2:0]  exp_size;
  } vec_t;

  rexp_t exp_q[$];
  int    total = 0;
  int    bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_check();
    rexp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rbeat_ok", 64'({inst_data_ok, data_data_ok}), 64'(e.is_data ? 2'b01 : 2'b10));
      chk("rbeat_data", 64'(e.is_data ? data_rdata : inst_rdata), 64'(e.val));
    end else if (inst_data_ok || data_data_ok) begin
      chk("spurious_data_ok", 64'({inst_data_ok, data_data_ok}), 64'(2'b00));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    sb_check();
  endtask

  task automatic drive_r(input logic [3:0] id, input logic [31:0] v);
    bus.rvalid = 1'b1;
    bus.rid    = id;
    bus.rdata  = v;
    if (id == 4'd0)
      exp_q.push_back('{is_data: 1'b0, val: v});
    else if (id == 4'd1)
      exp_q.push_back('{is_data: 1'b1, val: v});
  endtask

  task automatic clear_r();
    bus.rvalid = 1'b0;
  endtask

  function automatic logic [63:0] okp();
    return 64'({inst_addr_ok, data_addr_ok});
  endfunction

  initial begin
    vec_t       vecs[6];
    logic [1:0] starve_exp[6];
    logic [3:0] prev_id;

    vecs[0] = '{ireq:1'b1, dreq:1'b0, iaddr:32'h1C000000, isize:2'd2, daddr:32'h0, dsize:2'd0,
                rd:32'hDEADBEEF, exp_ok:2'b10, exp_id:4'd0, exp_addr:32'h1C000000, exp_size:3'd2};
    vecs[1] = '{ireq:1'b0, dreq:1'b1, iaddr:32'h0, isize:2'd0, daddr:32'h80001234, dsize:2'd0,
                rd:32'h12345678, exp_ok:2'b01, exp_id:4'd1, exp_addr:32'h80001234, exp_size:3'd0};
    vecs[2] = '{ireq:1'b1, dreq:1'b1, iaddr:32'hBFC00000, isize:2'd2, daddr:32'h00000010, dsize:2'd1,
                rd:32'hA5A55A5A, exp_ok:2'b01, exp_id:4'd1, exp_addr:32'h00000010, exp_size:3'd1};
    vecs[3] = '{ireq:1'b1, dreq:1'b0, iaddr:32'h00000004, isize:2'd3, daddr:32'h0, dsize:2'd0,
                rd:32'hCAFEF00D, exp_ok:2'b10, exp_id:4'd0, exp_addr:32'h00000004, exp_size:3'd3};
    vecs[4] = '{ireq:1'b1, dreq:1'b1, iaddr:32'h1C000008, isize:2'd2, daddr:32'hFFFFFFFC, dsize:2'd2,
                rd:32'h0F0F1234, exp_ok:2'b01, exp_id:4'd1, exp_addr:32'hFFFFFFFC, exp_size:3'd2};
    vecs[5] = '{ireq:1'b0, dreq:1'b0, iaddr:32'h0, isize:2'd0, daddr:32'h0, dsize:2'd0,
                rd:32'h0, exp_ok:2'b00, exp_id:4'd0, exp_addr:32'h0, exp_size:3'd0};

    starve_exp[0] = 2'b01; starve_exp[1] = 2'b01; starve_exp[2] = 2'b01;
    starve_exp[3] = 2'b01; starve_exp[4] = 2'b10; starve_exp[5] = 2'b01;

    // Reset with requests pending: nothing may be accepted
    resetn = 1'b0; inst_req = 1'b1; data_req = 1'b1;
    inst_addr = 32'h0; data_addr = 32'h0; inst_size = 2'd0; data_size = 2'd0;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rid = 4'd0; bus.rdata = 32'h0;
    step(); step();
    chk("rst_arvalid", 64'(bus.arvalid), 64'(0));
    chk("rst_araddr",  64'(bus.araddr), 64'(0));
    chk("rst_arsize",  64'(bus.arsize), 64'(0));
    chk("rst_arid",    64'(bus.arid), 64'(0));
    chk("rst_addr_ok", okp(), 64'(0));
    chk("rst_data_ok", 64'({inst_data_ok, data_data_ok}), 64'(0));
    chk("rst_rdata",   64'({inst_rdata, data_rdata}), 64'(0));
    chk("rst_rready",  64'(bus.rready), 64'(0));
    inst_req = 1'b0; data_req = 1'b0;
    resetn = 1'b1;
    step();
    chk("rready_up", 64'(bus.rready), 64'(1));

    // Vector table: one full transaction per entry
    for (int i = 0; i < 6; i++) begin
      inst_req = vecs[i].ireq; data_req = vecs[i].dreq;
      inst_addr = vecs[i].iaddr; inst_size = vecs[i].isize;
      data_addr = vecs[i].daddr; data_size = vecs[i].dsize;
      #1;
      chk($sformatf("v%0d_addr_ok", i), okp(), 64'(vecs[i].exp_ok));
      if (vecs[i].exp_ok != 2'b00) begin
        step();
        inst_req = 1'b0; data_req = 1'b0;
        chk($sformatf("v%0d_arvalid", i), 64'(bus.arvalid), 64'(1));
        chk($sformatf("v%0d_arid", i),    64'(bus.arid), 64'(vecs[i].exp_id));
        chk($sformatf("v%0d_araddr", i),  64'(bus.araddr), 64'(vecs[i].exp_addr));
        chk($sformatf("v%0d_arsize", i),  64'(bus.arsize), 64'(vecs[i].exp_size));
        bus.arready = 1'b1;
        step();
        bus.arready = 1'b0;
        chk($sformatf("v%0d_ar_done", i), 64'(bus.arvalid), 64'(0));
        drive_r(vecs[i].exp_id, vecs[i].rd);
        step();
        clear_r();
        step();
        chk($sformatf("v%0d_hold", i),
            64'((vecs[i].exp_id == 4'd0) ? inst_rdata : data_rdata), 64'(vecs[i].rd));
      end else begin
        step();
        chk($sformatf("v%0d_idle", i), 64'(bus.arvalid), 64'(0));
      end
    end

    // Both held, no returns: data, data, inst, inst, then both at their limit
    inst_req = 1'b1; data_req = 1'b1; inst_addr = 32'h1C000010; data_addr = 32'h00001000;
    bus.arready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("lim_g%0d", k), okp(), (k < 2) ? 64'(2'b01) : 64'(2'b10));
      step();
      step();
    end
    #1 chk("lim_none0", okp(), 64'(0));
    step();
    chk("lim_none1", okp(), 64'(0));
    inst_req = 1'b0;
    drive_r(4'd1, 32'h11110001);
    step();
    clear_r();
    #1 chk("lim_data_resume", okp(), 64'(2'b01));
    step();
    step();
    chk("lim_data_full", okp(), 64'(0));
    data_req = 1'b0;
    drive_r(4'd0, 32'h22220001); step();
    drive_r(4'd0, 32'h22220002); step();
    drive_r(4'd1, 32'h11110002); step();
    drive_r(4'd1, 32'h11110003); step();
    clear_r();
    step();

    // Immediate returns: four data grants, then inst, then data again
    inst_req = 1'b1; data_req = 1'b1; inst_addr = 32'h1C000100; data_addr = 32'h00002000;
    prev_id = 4'd0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0)
        drive_r(prev_id, 32'h50000000 + 32'(k));
      #1;
      chk($sformatf("starve_g%0d", k), okp(), 64'(starve_exp[k]));
      prev_id = (starve_exp[k] == 2'b10) ? 4'd0 : 4'd1;
      step();
      clear_r();
      step();
    end
    inst_req = 1'b0; data_req = 1'b0;
    drive_r(prev_id, 32'h5000000F);
    step();
    clear_r();
    bus.arready = 1'b0;
    step();

    // AR stall: request held stable, no accepts while waiting
    inst_req = 1'b1; inst_addr = 32'h1C000040; inst_size = 2'd2;
    #1 chk("stall_grant", okp(), 64'(2'b10));
    step();
    inst_req = 1'b0; data_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("stall_arvalid%0d", k), 64'(bus.arvalid), 64'(1));
      chk($sformatf("stall_araddr%0d", k), 64'(bus.araddr), 64'(32'h1C000040));
      chk($sformatf("stall_addr_ok%0d", k), okp(), 64'(0));
      step();
    end
    data_req = 1'b0;
    bus.arready = 1'b1;
    step();
    bus.arready = 1'b0;
    chk("stall_done", 64'(bus.arvalid), 64'(0));
    drive_r(4'd0, 32'h33330001);
    step();
    clear_r();
    step();

    // Issue and return of the same id in one cycle, then a stray id
    data_addr = 32'h00003000; data_size = 2'd2;
    data_req = 1'b1;
    #1 chk("same_a", okp(), 64'(2'b01));
    step();
    data_req = 1'b0; bus.arready = 1'b1;
    step();
    bus.arready = 1'b0;
    data_req = 1'b1;
    #1 chk("same_b", okp(), 64'(2'b01));
    step();
    data_req = 1'b0; bus.arready = 1'b1;
    drive_r(4'd1, 32'h0B0B0B0B);
    step();
    clear_r();
    bus.arready = 1'b0;
    data_req = 1'b1;
    #1 chk("same_c", okp(), 64'(2'b01));
    step();
    bus.arready = 1'b1;
    step();
    bus.arready = 1'b0;
    #1 chk("same_full0", okp(), 64'(0));
    step();
    chk("same_full1", okp(), 64'(0));
    drive_r(4'd7, 32'h77777777);
    step();
    clear_r();
    chk("rid7_data_ok", 64'({inst_data_ok, data_data_ok}), 64'(0));
    chk("rid7_hold", 64'(data_rdata), 64'(32'h0B0B0B0B));
    #1 chk("rid7_cnt", okp(), 64'(0));
    data_req = 1'b0;
    drive_r(4'd1, 32'h44440001); step();
    drive_r(4'd1, 32'h44440002); step();
    clear_r();
    step();

    // Reset in the middle of SEND
    data_addr = 32'h00004000; data_req = 1'b1;
    #1 chk("rs_g0", okp(), 64'(2'b01));
    step();
    data_req = 1'b0; bus.arready = 1'b1;
    step();
    bus.arready = 1'b0;
    data_req = 1'b1;
    #1 chk("rs_g1", okp(), 64'(2'b01));
    step();
    chk("rs_send", 64'(bus.arvalid), 64'(1));
    resetn = 1'b0;
    #1;
    chk("rs_async_drop", 64'(bus.arvalid), 64'(0));
    chk("rs_addr_ok", okp(), 64'(0));
    chk("rs_araddr", 64'(bus.araddr), 64'(0));
    chk("rs_rready", 64'(bus.rready), 64'(0));
    step();
    resetn = 1'b1;
    #1 chk("rs_first_grant", okp(), 64'(2'b01));
    step();
    bus.arready = 1'b1;
    step();
    bus.arready = 1'b0;
    #1 chk("rs_cnt_cleared", okp(), 64'(2'b01));
    step();
    bus.arready = 1'b1;
    step();
    bus.arready = 1'b0;
    #1 chk("rs_full", okp(), 64'(0));
    data_req = 1'b0;
    drive_r(4'd1, 32'h66660001); step();
    drive_r(4'd1, 32'h66660002); step();
    clear_r();
    step();

    chk("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
